// File: rtl/swpoll_pkg.sv
// swpoll_pkg: shared FSM encoding, register indices and control bit positions for switch_poll_ctrl.
package swpoll_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_EVAL} state_t;

    localparam logic [1:0] REG_STABLE  = 2'd0;
    localparam logic [1:0] REG_CHANGED = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_EVCNT   = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/switch_poll_ctrl_if.sv
// switch_poll_ctrl_if: Avalon-MM bus bundle, used for both the switch-reader master port and the host slave port.
interface switch_poll_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read, write, writedata, input readdata);
    modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/swpoll_debounce.sv
// swpoll_debounce: accepts a new switch value after DEBOUNCE_SAMPLES identical samples and keeps sticky change flags.
module swpoll_debounce #(
    parameter int SW_WIDTH         = 10,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SW_WIDTH-1:0] sample,
    input  logic                sample_valid,
    input  logic [SW_WIDTH-1:0] w1c_mask,
    output logic [SW_WIDTH-1:0] stable,
    output logic [SW_WIDTH-1:0] changed,
    output logic                change_evt
);
    localparam int CW = $clog2(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_SAMPLES - 1);

    logic [SW_WIDTH-1:0] candidate;
    logic [CW-1:0]       count, count_inc;

    assign count_inc  = (count == SAT) ? count : count + 1'b1;
    assign change_evt = sample_valid && sample == candidate && count_inc == SAT && candidate != stable;

    // Newly set change bits are OR-ed in after the clear so a coincident W1C loses.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            candidate <= '0;
            count     <= '0;
            stable    <= '0;
            changed   <= '0;
        end else begin
            changed <= (changed & ~w1c_mask) | (change_evt ? (stable ^ candidate) : '0);
            if (sample_valid) begin
                candidate <= sample;
                count     <= (sample == candidate) ? count_inc : '0;
            end
            if (change_evt) stable <= candidate;
        end

endmodule

// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: polls the switch reader over Avalon-MM, debounces SW and serves stable/changed/ctrl registers with a level irq.
// Define SWPOLL_EVENT_COUNT_EN to add the 16-bit accepted-change counter at register 3.
module switch_poll_ctrl
    import swpoll_pkg::*;
#(
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int SW_WIDTH         = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    switch_poll_ctrl_if.master m,
    switch_poll_ctrl_if.slave  s,
    output logic               irq
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);

    state_t              state, state_n;
    logic [TW-1:0]       timer, timer_n;
    logic [SW_WIDTH-1:0] sample, stable, changed, w1c_mask;
    logic [1:0]          ctrl;
    logic [15:0]         evcnt;
    logic [31:0]         rd;
    logic                wr, change_evt, unused_bits;

    assign wr          = s.chipselect & s.write;
    assign w1c_mask    = (wr && s.address == REG_CHANGED) ? s.writedata[SW_WIDTH-1:0] : '0;
    assign unused_bits = ^{s.writedata[31:SW_WIDTH], m.readdata[31:SW_WIDTH]};

    assign m.address    = 2'd0;
    assign m.chipselect = (state == S_REQ);
    assign m.read       = (state == S_REQ);
    assign m.write      = 1'b0;
    assign m.writedata  = '0;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state  <= S_IDLE;
            timer  <= '0;
            sample <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            if (state == S_CAPT) sample <= m.readdata[SW_WIDTH-1:0];
        end

    // Once REQ is issued the read/capture/evaluate sequence always completes, whatever enable does.
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            S_IDLE:
                if (!ctrl[CTRL_EN]) timer_n = RELOAD;
                else if (timer == '0) state_n = S_REQ;
                else timer_n = timer - 1'b1;
            S_REQ:  state_n = S_CAPT;
            S_CAPT: state_n = S_EVAL;
            S_EVAL: begin
                state_n = S_IDLE;
                timer_n = RELOAD;
            end
        endcase
    end

    swpoll_debounce #(
        .SW_WIDTH(SW_WIDTH),
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
        .clk(clk),
        .reset_n(reset_n),
        .sample(sample),
        .sample_valid(state == S_EVAL),
        .w1c_mask(w1c_mask),
        .stable(stable),
        .changed(changed),
        .change_evt(change_evt)
    );

`ifdef SWPOLL_EVENT_COUNT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) evcnt <= '0;
        else if (wr && s.address == REG_EVCNT) evcnt <= {15'd0, change_evt};
        else if (change_evt) evcnt <= evcnt + 16'd1;
`else
    assign evcnt = '0;
`endif

    always_comb begin
        rd = '0;
        case (s.address)
            REG_STABLE:  rd[SW_WIDTH-1:0] = stable;
            REG_CHANGED: rd[SW_WIDTH-1:0] = changed;
            REG_CTRL:    rd[1:0] = ctrl;
            REG_EVCNT:   rd[15:0] = evcnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ctrl       <= '0;
            s.readdata <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr && s.address == REG_CTRL) ctrl <= s.writedata[1:0];
            s.readdata <= (s.chipselect && s.read) ? rd : '0;
            irq        <= ctrl[CTRL_IRQ_EN] & (|changed);
        end

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// tb_switch_poll_ctrl: directed and randomized checks of switch_poll_ctrl against a sliding-window debounce model.
module tb_switch_poll_ctrl;
    localparam int P = 4;
    localparam int D = 3;
    localparam int W = 10;
`ifdef SWPOLL_EVENT_COUNT_EN
    localparam logic [31:0] EV_AFTER_TWO = 32'd2;
`else
    localparam logic [31:0] EV_AFTER_TWO = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         irq;
    logic [W-1:0] sw = '0;
    int           n_cmp = 0;
    int           n_fail = 0;
    int           mon_prints = 0;

    switch_poll_ctrl_if mif();
    switch_poll_ctrl_if sif();

    switch_poll_ctrl #(
        .POLL_CYCLES(P),
        .DEBOUNCE_SAMPLES(D),
        .SW_WIDTH(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m(mif),
        .s(sif),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Switch reader: returns the switches (with junk upper bits) the cycle after a read.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) mif.readdata <= '0;
        else if (mif.chipselect && mif.read) mif.readdata <= {22'($urandom()), sw};

    // Reference model: a value is accepted once the last D samples all agree on it.
    logic [W-1:0] exp_stable, exp_changed, pend_val;
    logic [1:0]   exp_ctrl;
    logic [15:0]  exp_ev;
    logic         exp_irq, req_now = 1'b0, prev_rd = 1'b0;
    logic [W-1:0] hist[$];
    int           pend;

    always @(posedge clk or negedge reset_n) begin
        logic [W-1:0] diff, w1c;
        logic         eq;
        if (!reset_n) begin
            exp_stable = '0; exp_changed = '0; exp_ctrl = '0; exp_ev = '0; exp_irq = 1'b0;
            hist.delete(); hist.push_back('0); pend = 0; pend_val = '0;
        end else begin
            diff = '0;
            if (pend == 1) begin
                hist.push_back(pend_val);
                if (hist.size() > D) void'(hist.pop_front());
                eq = (hist.size() == D);
                foreach (hist[i]) if (hist[i] != pend_val) eq = 1'b0;
                if (eq && pend_val != exp_stable) begin
                    diff = pend_val ^ exp_stable;
                    exp_stable = pend_val;
                end
            end
            if (pend != 0) pend--;
            if (req_now) begin
                pend = 2;
                pend_val = sw;
            end
            exp_irq = exp_ctrl[1] & (|exp_changed);
            w1c = (sif.chipselect && sif.write && sif.address == 2'd1) ? sif.writedata[W-1:0] : '0;
            exp_changed = (exp_changed & ~w1c) | diff;
            if (sif.chipselect && sif.write && sif.address == 2'd2) exp_ctrl = sif.writedata[1:0];
`ifdef SWPOLL_EVENT_COUNT_EN
            if (sif.chipselect && sif.write && sif.address == 2'd3) exp_ev = (diff != '0) ? 16'd1 : 16'd0;
            else if (diff != '0) exp_ev = exp_ev + 16'd1;
`endif
        end
    end

    always @(negedge clk) begin
        req_now = mif.read;
        if (reset_n) begin
            n_cmp++;
            if (irq !== exp_irq || mif.read !== mif.chipselect || mif.address !== 2'd0 ||
                mif.write !== 1'b0 || mif.writedata !== 32'd0 || (mif.read && prev_rd)) begin
                n_fail++;
                if (mon_prints < 10)
                    $display("FAIL monitor t=%0t irq=%b exp_irq=%b read=%b cs=%b addr=%0d wr=%b prev_read=%b",
                             $time, irq, exp_irq, mif.read, mif.chipselect, mif.address, mif.write, prev_rd);
                mon_prints++;
            end
        end
        prev_rd = mif.read;
    end

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {22'd0, exp_stable};
            2'd1:    return {22'd0, exp_changed};
            2'd2:    return {30'd0, exp_ctrl};
            default: return {16'd0, exp_ev};
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sif.chipselect = 1'b1; sif.write = 1'b1; sif.address = a; sif.writedata = d;
        @(negedge clk);
        sif.chipselect = 1'b0; sif.write = 1'b0; sif.writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] e);
        @(negedge clk);
        sif.chipselect = 1'b1; sif.read = 1'b1; sif.address = a;
        e = model_reg(a);
        @(negedge clk);
        d = sif.readdata;
        sif.chipselect = 1'b0; sif.read = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mif.read && k < 40);
        if (!mif.read) begin
            n_cmp++; n_fail++;
            $display("FAIL poll_timeout read=%b required=1", mif.read);
        end
    endtask

    task automatic wait_polls(input int n);
        repeat (n) wait_req();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        sif.chipselect = 0; sif.read = 0; sif.write = 0; sif.address = 0; sif.writedata = 0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mif.read, mif.chipselect, irq, sif.readdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs read=%b cs=%b irq=%b rdata=%h required all 0", mif.read, mif.chipselect, irq, sif.readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d, e);
            n_cmp++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d got=%h required=0", a, d); end
        end
        @(negedge clk);
        n_cmp++;
        if (sif.readdata !== 32'd0) begin n_fail++; $display("FAIL readdata_idle got=%h required=0", sif.readdata); end
    endtask

    task automatic test_poll_timing();
        repeat (2) @(negedge clk);
        bus_write(2'd2, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mif.read !== (k == 4 || k == 11)) begin
                n_fail++;
                $display("FAIL poll_timing cycle=%0d read=%b required=%b", k, mif.read, (k == 4 || k == 11));
            end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d, e;
        sw = 10'h2A5;
        wait_polls(2);
        bus_read(2'd0, d, e);
        n_cmp++;
        if (d !== 32'd0 || d !== e) begin n_fail++; $display("FAIL debounce_early got=%h required=%h", d, 32'd0); end
        wait_polls(1);
        bus_read(2'd0, d, e);
        n_cmp++;
        if (d !== 32'h2A5 || d !== e) begin n_fail++; $display("FAIL debounce_stable got=%h required=%h", d, 32'h2A5); end
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'h2A5 || d !== e) begin n_fail++; $display("FAIL debounce_changed got=%h required=%h", d, 32'h2A5); end
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL debounce_irq got=%b required=1", irq); end
    endtask

    task automatic test_w1c();
        logic [31:0] d, e;
        bus_write(2'd1, 32'h005);
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'h2A0 || d !== e) begin n_fail++; $display("FAIL w1c_partial got=%h required=%h", d, 32'h2A0); end
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_hold got=%b required=1", irq); end
        bus_write(2'd1, 32'h2A0);
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_lag got=%b required=1", irq); end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_fall got=%b required=0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        wait_polls(1);
        sw = 10'h3FF;
        wait_polls(2);
        sw = 10'h2A5;
        wait_polls(4);
        bus_read(2'd0, d, e);
        n_cmp++;
        if (d !== 32'h2A5 || d !== e) begin n_fail++; $display("FAIL glitch_stable got=%h required=%h", d, 32'h2A5); end
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'd0 || d !== e) begin n_fail++; $display("FAIL glitch_changed got=%h required=0", d); end
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got=%b required=0", irq); end
    endtask

    task automatic test_collision();
        logic [31:0] d, e;
        wait_polls(1);
        sw = 10'h2A4;
        wait_polls(3);
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'h001 || d !== e) begin n_fail++; $display("FAIL collision_setup got=%h required=%h", d, 32'h001); end
        sw = 10'h2A5;
        wait_polls(2);
        wait_req();
        @(negedge clk);
        bus_write(2'd1, 32'h001);
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'h001 || d !== e) begin n_fail++; $display("FAIL collision_set_wins got=%h required=%h", d, 32'h001); end
        bus_read(2'd0, d, e);
        n_cmp++;
        if (d !== 32'h2A5 || d !== e) begin n_fail++; $display("FAIL collision_stable got=%h required=%h", d, 32'h2A5); end
    endtask

    task automatic test_irq_en();
        logic [31:0] d, e;
        bus_write(2'd2, 32'h1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b required=0", irq); end
        bus_read(2'd1, d, e);
        n_cmp++;
        if (d !== 32'h001 || d !== e) begin n_fail++; $display("FAIL irq_masked_changed got=%h required=%h", d, 32'h001); end
        bus_read(2'd2, d, e);
        n_cmp++;
        if (d !== 32'h1 || d !== e) begin n_fail++; $display("FAIL ctrl_readback got=%h required=1", d); end
        bus_write(2'd2, 32'h3);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked got=%b required=1", irq); end
    endtask

    task automatic test_event_count();
        logic [31:0] d, e;
        wait_polls(1);
        bus_write(2'd3, 32'hFFFF);
        sw = 10'h155;
        wait_polls(3);
        sw = 10'h0AA;
        wait_polls(3);
        bus_read(2'd3, d, e);
        n_cmp++;
        if (d !== EV_AFTER_TWO || d !== e) begin n_fail++; $display("FAIL event_count got=%h required=%h", d, EV_AFTER_TWO); end
        bus_read(2'd0, d, e);
        n_cmp++;
        if (d !== 32'h0AA || d !== e) begin n_fail++; $display("FAIL event_stable got=%h required=%h", d, 32'h0AA); end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [1:0]  a;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) sw = W'($urandom());
            else if ($urandom_range(0, 3) == 0) sw = sw ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 4) == 0) bus_write(2'd1, $urandom());
            if ($urandom_range(0, 7) == 0) bus_write(2'd2, 32'($urandom_range(0, 3)));
            else if ($urandom_range(0, 3) == 0) bus_write(2'd2, 32'h3);
            if ($urandom_range(0, 15) == 0) bus_write(2'd3, $urandom());
            repeat ($urandom_range(1, 25)) @(negedge clk);
            a = 2'($urandom_range(0, 3));
            bus_read(a, d, e);
            n_cmp++;
            if (d !== e) begin n_fail++; $display("FAIL random it=%0d reg=%0d got=%h required=%h", it, a, d, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d, e;
        bus_write(2'd2, 32'h3);
        wait_req();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mif.read, mif.chipselect, irq, sif.readdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset read=%b cs=%b irq=%b rdata=%h required all 0", mif.read, mif.chipselect, irq, sif.readdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d, e);
            n_cmp++;
            if (d !== 32'd0 || d !== e) begin n_fail++; $display("FAIL async_reset_reg%0d got=%h required=0", a, d); end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mif.read !== 1'b0) begin n_fail++; $display("FAIL async_reset_idle cycle=%0d read=%b required=0", k, mif.read); end
        end
    endtask

    initial begin
        test_reset();
        test_poll_timing();
        test_debounce();
        test_w1c();
        test_glitch();
        test_collision();
        test_irq_en();
        test_event_count();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
